// File: rtl/bsg_cache_pkg.sv
// bsg_cache_pkg: shared definitions for the bsg_cache DMA interface.
//   `BSG_CACHE_DMA_PKT_WIDTH(addr_w, mask_w)  - packed width of a DMA packet
//   `DECLARE_BSG_CACHE_DMA_PKT_S(addr_w, mask_w) - packet struct {write_not_read, addr, mask}
//   block_offset_width()                       - byte-offset bits covered by one cache block

`ifndef BSG_CACHE_PKG_MACROS
`define BSG_CACHE_PKG_MACROS

`define BSG_CACHE_DMA_PKT_WIDTH(addr_width_mp, mask_width_mp) \
  (1 + (addr_width_mp) + (mask_width_mp))

`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp, mask_width_mp) \
  typedef struct packed {                   \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr;           \
    logic [mask_width_mp-1:0] mask;           \
  } bsg_cache_dma_pkt_s

`endif

package bsg_cache_pkg;

  // Number of low byte-address bits that select a byte within one block.
  function automatic int block_offset_width(input int data_width, input int block_words);
    return $clog2(data_width / 8) + $clog2(block_words);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// bsg_mem_1r1w: one write port, one asynchronous read port word memory.
//   w_clk_i   write clock
//   w_v_i     write enable
//   w_addr_i  write word address
//   w_data_i  write data
//   r_addr_i  read word address
//   r_data_o  read data (combinational from r_addr_i)
// With read_write_same_addr_p = 0 a same-address read during a write returns
// the old contents; otherwise the incoming write data is forwarded.

module bsg_mem_1r1w #(
  parameter int width_p                = 64,
  parameter int els_p                  = 1024,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp         = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // NOTE: the storage array has no reset; clearing thousands of words would
  // force it into flops instead of RAM, and its contents are defined by use.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  always_comb begin
    r_data_o = mem_r[r_addr_i];
    if ((read_write_same_addr_p != 0) && w_v_i && (w_addr_i == r_addr_i))
      r_data_o = w_data_i;
  end

endmodule

// File: rtl/bsg_cache_dma_mem_responder.sv
// bsg_cache_dma_mem_responder: memory-side responder for the bsg_cache DMA port.
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   dma_pkt_i / _v_i / _yumi_o     packet in: {write_not_read, addr, mask}
//   dma_data_o / _v_o / _ready_i   fill words streamed out of local memory
//   dma_data_i / _v_i / _yumi_o    evict words absorbed into local memory (masked)
// One block transfer per packet; block index taken from addr with the in-block
// offset bits dropped and the upper bits wrapping modulo the memory size.

module bsg_cache_dma_mem_responder
  import bsg_cache_pkg::*;
#(
  parameter int addr_width_p          = 30,
  parameter int data_width_p          = 64,
  parameter int block_size_in_words_p = 8,
  parameter int els_p                 = 1024,
  localparam int dma_pkt_width_lp     = `BSG_CACHE_DMA_PKT_WIDTH(addr_width_p, block_size_in_words_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,

  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,

  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o
);

  `DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_p, block_size_in_words_p);

  localparam int lg_block_lp  = $clog2(block_size_in_words_p);
  localparam int lg_els_lp    = $clog2(els_p);
  localparam int blk_width_lp = lg_els_lp - lg_block_lp;
  localparam int offset_lp    = block_offset_width(data_width_p, block_size_in_words_p);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  bsg_cache_dma_pkt_s dma_pkt;
  assign dma_pkt = dma_pkt_i;

  // Offset bits and bits above the memory size are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dma_pkt.addr;

  state_e                             state_q, state_d;
  logic [lg_block_lp-1:0]             cnt_q, cnt_d;
  logic [blk_width_lp-1:0]            blk_q, blk_d;
  logic [block_size_in_words_p-1:0]   mask_q, mask_d;

  logic                               last_beat;
  logic                               mem_w_v;
  logic [lg_els_lp-1:0]               mem_addr;

  assign last_beat = (cnt_q == {lg_block_lp{1'b1}});
  assign mem_addr  = {blk_q, cnt_q};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      mask_q  <= mask_d;
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (dma_pkt_v_i) begin
          state_d = dma_pkt.write_not_read ? WRITE : READ;
          cnt_d   = '0;
          blk_d   = dma_pkt.addr[offset_lp +: blk_width_lp];
          mask_d  = dma_pkt.mask;
        end
      end
      READ: begin
        if (dma_data_ready_i) begin
          cnt_d = cnt_q + lg_block_lp'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      WRITE: begin
        if (dma_data_v_i) begin
          cnt_d = cnt_q + lg_block_lp'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dma_pkt_yumi_o  = (state_q == IDLE)  && dma_pkt_v_i;
    dma_data_v_o    = (state_q == READ);
    dma_data_yumi_o = (state_q == WRITE) && dma_data_v_i;
    // Masked-off evict words are still consumed, just not stored.
    mem_w_v         = dma_data_yumi_o && mask_q[cnt_q];
  end

  bsg_mem_1r1w #(
    .width_p               (data_width_p),
    .els_p                 (els_p),
    .read_write_same_addr_p(0)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (mem_addr),
    .w_data_i (dma_data_i),
    .r_addr_i (mem_addr),
    .r_data_o (dma_data_o)
  );

endmodule

// File: doc/bsg_cache_dma_mem_responder.md
# bsg_cache_dma_mem_responder

Synthesizable DMA responder for the `bsg_cache` DMA interface: accepts cache DMA packets, streams fill blocks from a local word memory and absorbs masked eviction blocks into it. It sits on the memory side of the DMA port, in place of a nonsynthesizable DMA model, e.g. behind a cache in FPGA or emulation builds.

## Interface
- addr_width_p, 30, byte address width of DMA packets
- data_width_p, 64, DMA data word width in bits (power of 2, ≥ 8)
- block_size_in_words_p, 8, words per cache block (power of 2, ≥ 2); also the mask width
- els_p, 1024, memory depth in words (power of 2, multiple of block_size_in_words_p)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- dma_pkt_i  in  `bsg_cache_dma_pkt_width(addr_width_p, block_size_in_words_p)`  packet {write_not_read, addr, mask}
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_yumi_o  out  1  packet consumed this cycle
- dma_data_o  out  data_width_p  fill word to cache
- dma_data_v_o  out  1  fill word valid
- dma_data_ready_i  in  1  cache can take fill word
- dma_data_i  in  data_width_p  evict word from cache
- dma_data_v_i  in  1  evict word valid
- dma_data_yumi_o  out  1  evict word consumed this cycle

## Operation
- FSM states: IDLE, READ, WRITE. Word counter cnt_r of width lg(block_size_in_words_p). Latched block index blk_r.
- IDLE: dma_pkt_yumi_o = dma_pkt_v_i. On yumi: blk_r <= (addr >> lg(data_width_p/8+... block bytes)) mod (els_p/block_size_in_words_p), i.e. the block-offset bits of addr are ignored; cnt_r <= 0; next state is READ if write_not_read=0, WRITE otherwise; mask latched into mask_r.
- READ: dma_data_v_o = 1; dma_data_o = mem[{blk_r, cnt_r}]. Beat when dma_data_ready_i=1: cnt_r++. On the beat with cnt_r = block_size_in_words_p-1 go to IDLE. Mask is ignored on reads.
- WRITE: dma_data_yumi_o = dma_data_v_i. On yumi: if mask_r[cnt_r] write dma_data_i to mem[{blk_r, cnt_r}], else discard; cnt_r++. Last beat → IDLE. An all-zero mask still consumes all block_size_in_words_p words.
- dma_pkt_yumi_o = 0 outside IDLE; dma_data_yumi_o = 0 outside WRITE; dma_data_v_o = 0 outside READ.
- Address wrap: addresses beyond els_p words alias modulo els_p; no error signalled.
- Reset (any time, including mid-block): state → IDLE, cnt_r → 0, partial transfers abandoned; words already written stay written. Memory contents are not initialized by reset.

## Timing
- Reset values: dma_pkt_yumi_o=0, dma_data_v_o=0, dma_data_yumi_o=0, dma_data_o don't-care.
- Packet accepted in cycle t (yumi combinational on v_i in IDLE); first fill word valid in t+1.
- Fill: one word per cycle while ready_i high; dma_data_v_o never deasserts mid-block; data stable while held.
- Evict: yumi combinational from v_i; one word per cycle max.
- Last beat in cycle u → IDLE in u+1; next packet accepted no earlier than u+1. Minimum per-block occupancy: block_size_in_words_p+1 cycles.
- Memory read combinational from {blk_r, cnt_r}; write takes effect at the end of the yumi cycle; a fill issued the cycle after an evict to the same block returns new data.

## Structure
- DMA packet struct and width macro come from bsg_cache_pkg (`declare_bsg_cache_dma_pkt_s`); the FSM state enum is local to the module.
- One sub-module: bsg_mem_1r1w (width data_width_p, els_p, read_write_same_addr_p=0) for storage; no per-word write enables beyond mask_r gating.

## Test plan
- Write to addr 0x0, mask 0xFF, words 0x1000..0x1007; then read 0x0 → fill words 0x1000..0x1007 in order.
- Preload as above, write to 0x0 with mask 0x0F, words 0xA0..0xA7; read → 0xA0..0xA3, 0x1004..0x1007.
- Read with dma_data_ready_i random 50%: exactly 8 beats, in order, no duplicates, v_o held; pkt_yumi_o stays 0 until the cycle after the last beat.
- Back-to-back packets with dma_pkt_v_i held high: second yumi occurs exactly one cycle after the first block's last beat.
- Address wrap: write block at byte addr els_p*8 (=0x2000 with default parameters), read addr 0x0 → same data; addr 0x1C reads block 0 (offset bits ignored).
- Assert reset after beat 3 of a read: outputs return to 0 immediately; the next read of the same block returns all 8 words from word 0.
